// File: rtl/block_writer_if.sv
// Block writer bus: accumulator-side block inputs and result-memory write port.
// Latency: none, plain signal bundle.
// Backpressure: mem_ready stalls the writer; the block inputs have no ready.
interface block_writer_if #(
  parameter int ADDR_W = 6
);
  logic [31:0]       i_c11;
  logic [31:0]       i_c12;
  logic [31:0]       i_c21;
  logic [31:0]       i_c22;
  logic              i_valid;
  logic              i_last;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_data;
  logic              mem_we;
  logic              mem_ready;

  // Writer side.
  modport master (
    input  i_c11, i_c12, i_c21, i_c22, i_valid, i_last, mem_ready,
    output mem_addr, mem_data, mem_we
  );

  // Accumulator and memory side.
  modport slave (
    output i_c11, i_c12, i_c21, i_c22, i_valid, i_last, mem_ready,
    input  mem_addr, mem_data, mem_we
  );
endinterface

// File: rtl/block_writer.sv
// Block writer: scatters each final 2x2 accumulated block into a 2*N_BLK square result matrix.
// Latency: first write the cycle after capture; 4 write cycles + 1 advance cycle per block.
// Backpressure: mem_ready low holds the pending write indefinitely; blocks arriving while busy are dropped (sticky overflow).
// Optional feature macro ACC_CLEAR_EN adds the acc_clear output (one pulse per block in S_ADV).
module block_writer #(
  parameter int N_BLK  = 4,
  parameter int ADDR_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  block_writer_if.master     bus,
  output logic               busy,
  output logic               overflow,
  output logic               frame_done
`ifdef ACC_CLEAR_EN
  ,
  output logic               acc_clear
`endif
);

  localparam int CW   = (N_BLK > 1) ? $clog2(N_BLK) : 1;
  localparam int SIDE = 2 * N_BLK;
  localparam logic [CW-1:0] LAST_IDX = CW'(N_BLK - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_ADV   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [3:0][31:0]  c_q;       // captured block, index 0..3 = c11, c12, c21, c22
  logic [1:0]        k;         // word index within the block
  logic [CW-1:0]     br;        // block row
  logic [CW-1:0]     bc;        // block column
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic              ovf_q;

  logic              capture;
  logic              accepted;
  logic              qualified;
  logic              frame_wrap;

  // Element address of word kk in block (r,c): row 2r+kk[1], column 2c+kk[0].
  function automatic logic [ADDR_W-1:0] elem_addr(input logic [CW-1:0] r,
                                                  input logic [CW-1:0] c,
                                                  input logic [1:0]    kk);
    logic [31:0] a;
    a = (32'd2 * 32'(r) + 32'(kk[1])) * 32'(SIDE) + 32'd2 * 32'(c) + 32'(kk[0]);
    return a[ADDR_W-1:0];
  endfunction

  assign qualified  = bus.i_valid && bus.i_last;
  assign capture    = (state == S_IDLE) && qualified;
  assign accepted   = we_q && bus.mem_ready;
  assign frame_wrap = (br == LAST_IDX) && (bc == LAST_IDX);

  assign bus.mem_we   = we_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_data = data_q;
  assign overflow     = ovf_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-state status outputs; reset forces the status outputs low.
  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    frame_done = 1'b0;
`ifdef ACC_CLEAR_EN
    acc_clear  = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (capture) begin
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        busy = 1'b1;
        if (accepted && (k == 2'd3)) begin
          state_nxt = S_ADV;
        end
      end
      S_ADV: begin
        busy       = 1'b1;
        frame_done = frame_wrap;
`ifdef ACC_CLEAR_EN
        acc_clear  = 1'b1;
`endif
        state_nxt  = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    if (reset) begin
      busy       = 1'b0;
      frame_done = 1'b0;
`ifdef ACC_CLEAR_EN
      acc_clear  = 1'b0;
`endif
    end
  end

  // Capture, registered write port and word sequencing; addr/data only move on an accepted write.
  always_ff @(posedge clk) begin
    if (reset) begin
      c_q    <= '0;
      k      <= 2'd0;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (capture) begin
            c_q    <= {bus.i_c22, bus.i_c21, bus.i_c12, bus.i_c11};
            k      <= 2'd0;
            we_q   <= 1'b1;
            addr_q <= elem_addr(br, bc, 2'd0);
            data_q <= bus.i_c11;
          end
        end
        S_WRITE: begin
          if (accepted) begin
            if (k == 2'd3) begin
              we_q <= 1'b0;
            end else begin
              k      <= k + 2'd1;
              addr_q <= elem_addr(br, bc, k + 2'd1);
              data_q <= c_q[k + 2'd1];
            end
          end
        end
        S_ADV: begin
          k <= 2'd0;
        end
        default: begin
          we_q <= 1'b0;
        end
      endcase
    end
  end

  // Block position: column first, row on column wrap, both back to zero after the last block.
  always_ff @(posedge clk) begin
    if (reset) begin
      br <= '0;
      bc <= '0;
    end else if (state == S_ADV) begin
      if (bc == LAST_IDX) begin
        bc <= '0;
        if (br == LAST_IDX) begin
          br <= '0;
        end else begin
          br <= br + 1'b1;
        end
      end else begin
        bc <= bc + 1'b1;
      end
    end
  end

  // Sticky drop flag: any final block presented while a block is in flight is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if ((state != S_IDLE) && qualified) begin
      ovf_q <= 1'b1;
    end
  end

endmodule
